// File: rtl/alu_exec_unit_pkg.sv
// alu_pkg: operation encodings, FSM states and op classification shared by the execute-stage ALU.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SLT = 4'b0100,
    OP_SUB = 4'b0110,
    OP_EQ  = 4'b1000,
    OP_SLL = 4'b1001,
    OP_SRL = 4'b1010,
    OP_SRA = 4'b1011
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(logic [3:0] op);
    return op == OP_SLL || op == OP_SRL || op == OP_SRA;
  endfunction
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_if: operation request and result handshake between issue logic and the ALU.
interface alu_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  modport master(output in_valid, op, a, b, out_ready, input in_ready, out_valid, result, zero, illegal);
  modport slave(input in_valid, op, a, b, out_ready, output in_ready, out_valid, result, zero, illegal);
endinterface

// File: rtl/alu_exec_unit_comb_core.sv
// alu_comb_core: single-cycle logic/arith/compare ops; shift codes are legal but produce 0 here.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] comb_result_o,
  output logic             illegal_o
);
  always_comb begin
    comb_result_o = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_AND: comb_result_o = a_i & b_i;
      OP_OR:  comb_result_o = a_i | b_i;
      OP_ADD: comb_result_o = a_i + b_i;
      OP_XOR: comb_result_o = a_i ^ b_i;
      OP_SLT: comb_result_o = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      OP_SUB, OP_EQ: comb_result_o = a_i - b_i;
      OP_SLL, OP_SRL, OP_SRA: comb_result_o = '0;
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with 1-cycle ops and a 1-bit/cycle iterative shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  alu_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  alu_op_t            op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d, result_q, result_d, comb_result, shifted;
  logic [SHAMT_W-1:0] cnt_q, cnt_d, shamt;
  logic               zero_q, zero_d, illegal_q, illegal_d, comb_illegal;
  logic               accept, start_shift, last_shift;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op_i         (bus.op),
    .a_i          (bus.a),
    .b_i          (bus.b),
    .comb_result_o(comb_result),
    .illegal_o    (comb_illegal)
  );

  assign shamt       = bus.b[SHAMT_W-1:0];
  assign accept      = bus.in_valid && bus.in_ready;
  assign start_shift = is_shift_op(bus.op) && shamt != '0;
  assign last_shift  = state_q == S_SHIFT && cnt_q == SHAMT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = start_shift ? S_SHIFT : S_DONE;
    else if (last_shift) state_d = S_DONE;
    else if (state_q == S_DONE && bus.out_ready) state_d = S_IDLE;
  end

  always_comb begin
    bus.in_ready  = state_q == S_IDLE || (state_q == S_DONE && bus.out_ready);
    bus.out_valid = state_q == S_DONE;
    bus.result    = result_q;
    bus.zero      = zero_q;
    bus.illegal   = illegal_q;
  end

  always_comb begin
    shifted = op_q == OP_SLL ? {acc_q[WIDTH-2:0], 1'b0}
            : op_q == OP_SRA ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}
            : {1'b0, acc_q[WIDTH-1:1]};
  end

  // Operands are captured only at accept so later input changes cannot disturb an op in flight.
  always_comb begin
    op_d = op_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    result_d = result_q;
    zero_d = zero_q;
    illegal_d = illegal_q;
    if (accept) begin
      op_d = alu_op_t'(bus.op);
      acc_d = bus.a;
      cnt_d = shamt;
      if (!start_shift) begin
        result_d = is_shift_op(bus.op) ? bus.a : comb_result;
        zero_d = result_d == '0;
        illegal_d = comb_illegal;
      end
    end else if (state_q == S_SHIFT) begin
      acc_d = shifted;
      cnt_d = cnt_q - SHAMT_W'(1);
      if (last_shift) begin
        result_d = shifted;
        zero_d = shifted == '0;
        illegal_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= OP_AND;
      acc_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
      zero_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      op_q <= op_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      zero_q <= zero_d;
      illegal_q <= illegal_d;
    end
  end
endmodule
